pic_host_sequencer: RTL

CPU-side bus initiator for the 8259 PIC `Control_logic` block. It drives the PIC's write, read, A0 and INTA strobes and its bidirectional data bus. It programs the PIC (ICW1–ICW4, then OCW1) and services `INT` with the two-pulse INTA sequence, capturing the vector. It issues a non-specific EOI when auto-EOI is off, and performs IRR/ISR status reads through OCW3.

---
 rtl/pic_pkg.sv | 89 ++++++++
 rtl/pic_strobe_timer.sv | 30 +++
 rtl/pic_host_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared encodings and byte-selection helpers for the 8259 host sequencer.
package pic_pkg;

  // Sequencer states (plain constants so older tools can share the encoding)
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_SETUP = 4'd1;
  localparam logic [3:0] S_W_ACT   = 4'd2;
  localparam logic [3:0] S_W_REC   = 4'd3;
  localparam logic [3:0] S_R_SETUP = 4'd4;
  localparam logic [3:0] S_R_ACT   = 4'd5;
  localparam logic [3:0] S_R_REC   = 4'd6;
  localparam logic [3:0] S_A1_ACT  = 4'd7;
  localparam logic [3:0] S_A_GAP   = 4'd8;
  localparam logic [3:0] S_A2_ACT  = 4'd9;
  localparam logic [3:0] S_A_REC   = 4'd10;
  localparam logic [3:0] S_DONE    = 4'd11;

  // Command bytes
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;
  localparam logic [7:0] OCW3_RD_IRR = 8'h0A;
  localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

  // Control-word bit positions
  localparam int IC4  = 0;
  localparam int SNGL = 1;
  localparam int AEOI = 1;

  // Which byte the current write cycle carries
  typedef enum logic [2:0] {
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4,
    STEP_OCW1,
    STEP_EOI,
    STEP_OCW3
  } step_e;

  typedef struct packed {
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic [7:0] ocw1;
  } init_bytes_t;

  // Byte driven on the bus for a given write step
  function automatic logic [7:0] step_byte(input step_e s, input init_bytes_t b,
                                           input logic rd_sel);
    logic [7:0] r;
    r = 8'h00;
    case (s)
      STEP_ICW1: r = b.icw1;
      STEP_ICW2: r = b.icw2;
      STEP_ICW3: r = b.icw3;
      STEP_ICW4: r = b.icw4;
      STEP_OCW1: r = b.ocw1;
      STEP_EOI:  r = OCW2_NS_EOI;
      STEP_OCW3: r = rd_sel ? OCW3_RD_ISR : OCW3_RD_IRR;
      default:   r = 8'h00;
    endcase
    return r;
  endfunction

  // ICW1, EOI and OCW3 go to the even address; everything else to the odd one
  function automatic logic step_a0(input step_e s);
    logic r;
    r = 1'b0;
    case (s)
      STEP_ICW2, STEP_ICW3, STEP_ICW4, STEP_OCW1: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Successor of an init step; ICW3/ICW4 are skipped according to ICW1
  function automatic step_e next_init_step(input step_e s, input logic [7:0] icw1);
    step_e r;
    r = STEP_OCW1;
    case (s)
      STEP_ICW1: r = STEP_ICW2;
      STEP_ICW2: r = !icw1[SNGL] ? STEP_ICW3 : (icw1[IC4] ? STEP_ICW4 : STEP_OCW1);
      STEP_ICW3: r = icw1[IC4] ? STEP_ICW4 : STEP_OCW1;
      default:   r = STEP_OCW1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Phase-duration down-counter: loaded with (cycles-1) on state entry,
// expired during the last cycle of the phase.
module pic_strobe_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == '0);

  // Reload on entry, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pic_host_sequencer.sv
// CPU-side bus initiator for the 8259: init writes, INTA service with
// optional non-specific EOI, and IRR/ISR status reads via OCW3.
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       rd_req,
  input  logic       rd_sel,
  input  logic       INT,
  output logic       WD,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  inout  wire  [7:0] data_bus,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] status,
  output logic       status_valid,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_CYC = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  logic [3:0]  state_q, state_d;
  step_e       step_q, step_d;
  init_bytes_t bytes_q, bytes_d;
  logic        rd_sel_q, rd_sel_d;
  logic        aeoi_q, aeoi_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  vector_q, vector_d;
  logic [7:0]  status_q, status_d;
  logic        vvalid_q, vvalid_d;
  logic        svalid_q, svalid_d;

  logic          tmr_load, tmr_exp;
  logic [CW-1:0] tmr_val;

  logic in_wcycle;

  pic_strobe_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Outputs decode straight from state so reset releases strobes in one edge
  assign in_wcycle    = (state_q == S_W_SETUP) || (state_q == S_W_ACT) || (state_q == S_W_REC);
  assign WD           = (state_q != S_W_ACT);
  assign RD           = (state_q != S_R_ACT);
  assign INTA         = !((state_q == S_A1_ACT) || (state_q == S_A2_ACT));
  assign A0           = in_wcycle ? step_a0(step_q) : 1'b0;
  assign data_bus     = (state_q == S_W_ACT) ? step_byte(step_q, bytes_q, rd_sel_q) : 8'bz;
  assign vector       = vector_q;
  assign vector_valid = vvalid_q;
  assign status       = status_q;
  assign status_valid = svalid_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != S_IDLE);

  // Phase length for the state being entered; reload on every state change
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      S_W_ACT, S_R_ACT, S_A1_ACT, S_A2_ACT: tmr_val = CW'(STROBE_CYCLES - 1);
      S_W_REC, S_R_REC, S_A_GAP, S_A_REC:   tmr_val = CW'(RECOVERY_CYCLES - 1);
      default:                              tmr_val = '0;
    endcase
  end

  // Sequencer: arbitration in IDLE, then walk the bus-cycle phases
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    bytes_d     = bytes_q;
    rd_sel_d    = rd_sel_q;
    aeoi_d      = aeoi_q;
    init_done_d = init_done_q;
    vector_d    = vector_q;
    status_d    = status_q;
    vvalid_d    = 1'b0;
    svalid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_init) begin
          bytes_d     = '{icw1: icw1, icw2: icw2, icw3: icw3, icw4: icw4, ocw1: ocw1};
          // AEOI only counts when ICW4 is actually written
          aeoi_d      = icw1[IC4] & icw4[AEOI];
          init_done_d = 1'b0;
          step_d      = STEP_ICW1;
          state_d     = S_W_SETUP;
        end else if (INT && init_done_q) begin
          state_d = S_A1_ACT;
        end else if (rd_req && init_done_q) begin
          rd_sel_d = rd_sel;
          step_d   = STEP_OCW3;
          state_d  = S_W_SETUP;
        end
      end
      S_W_SETUP: if (tmr_exp) state_d = S_W_ACT;
      S_W_ACT:   if (tmr_exp) state_d = S_W_REC;
      S_W_REC: begin
        if (tmr_exp) begin
          case (step_q)
            STEP_OCW1: begin
              state_d     = S_DONE;
              init_done_d = 1'b1;
            end
            STEP_OCW3: state_d = S_R_SETUP;
            STEP_EOI:  state_d = S_IDLE;
            default: begin
              step_d  = next_init_step(step_q, bytes_q.icw1);
              state_d = S_W_SETUP;
            end
          endcase
        end
      end
      S_R_SETUP: if (tmr_exp) state_d = S_R_ACT;
      S_R_ACT: begin
        if (tmr_exp) begin
          status_d = data_bus;
          svalid_d = 1'b1;
          state_d  = S_R_REC;
        end
      end
      S_R_REC:  if (tmr_exp) state_d = S_IDLE;
      S_A1_ACT: if (tmr_exp) state_d = S_A_GAP;
      S_A_GAP:  if (tmr_exp) state_d = S_A2_ACT;
      S_A2_ACT: begin
        if (tmr_exp) begin
          vector_d = data_bus;
          vvalid_d = 1'b1;
          state_d  = S_A_REC;
        end
      end
      S_A_REC: begin
        if (tmr_exp) begin
          if (aeoi_q) begin
            state_d = S_IDLE;
          end else begin
            step_d  = STEP_EOI;
            state_d = S_W_SETUP;
          end
        end
      end
      // One-cycle tail after init so init_done is visible before new requests
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= STEP_ICW1;
      bytes_q     <= '0;
      rd_sel_q    <= 1'b0;
      aeoi_q      <= 1'b0;
      init_done_q <= 1'b0;
      vector_q    <= 8'h00;
      status_q    <= 8'h00;
      vvalid_q    <= 1'b0;
      svalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      bytes_q     <= bytes_d;
      rd_sel_q    <= rd_sel_d;
      aeoi_q      <= aeoi_d;
      init_done_q <= init_done_d;
      vector_q    <= vector_d;
      status_q    <= status_d;
      vvalid_q    <= vvalid_d;
      svalid_q    <= svalid_d;
    end
  end

endmodule
